simon_round_ctrl: RTL and testbench
===================================

# simon_round_ctrl

Sequencer for one Simon 32/64 block operation. It accepts a 32-bit block and a 64-bit key over a valid/ready handshake, and drives the key_expansion engine through its hold/load input. It applies 32 Feistel rounds, consuming each round key as soon as its `key_ready` flag is set, and returns the result over a valid/ready handshake. It sits between the bus-facing wrapper and key_expansion, and owns the only round datapath.

## Interface
Parameters:
- `ROUNDS`, default 32: number of rounds. Must equal the key_expansion depth.
- `WORD`, default 16: Simon word width in bits.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: block request.
- `in_ready` out 1: high only in IDLE.
- `in_data` in 32: `[31:16]`=x, `[15:0]`=y.
- `in_key` in 64: `[16i+15:16i]` = key word k[i]; k[0] is the first round key.
- `in_new_key` in 1: force a key reload. Ignored when no key is loaded, because a reload happens anyway.
- `in_decrypt` in 1: decrypt request. Used only with `SIMON_DECRYPT_EN`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 32: result, same packing as `in_data`.
- `ks_hold` out 1: connects to key_expansion `wait_data`.
- `ks_key` out 4x16: connects to key_expansion `k_in`.
- `ks_ready` in 32x1: from key_expansion `key_ready`.
- `ks_rk` in 32x16: from key_expansion `k_out`.
- `busy` out 1: state is not IDLE.
- `round_idx` out 5: round currently being applied.

## Operation
States and transitions:
- IDLE → LOAD_KEY or RUN, on `in_valid`.
- LOAD_KEY → RUN, after 1 cycle.
- RUN → DONE, after the last round.
- DONE → IDLE, on `out_ready`.

Accept (IDLE, `in_valid`):
- Register x, y and the mode.
- If `!key_loaded || in_new_key`: register `ks_key` from `in_key` and go to LOAD_KEY.
- Otherwise go straight to RUN, reusing the cached schedule.

LOAD_KEY:
- `ks_hold`=1 for exactly one cycle; key_expansion loads k[0..3] at the closing edge.
- Set `key_loaded`=1.

RUN:
- Index `idx` starts at 0 for encrypt and 31 for decrypt.
- Each cycle with `ks_ready[idx]`=1, apply one round with k=`ks_rk[idx]`:
  - f(v) = (rol1(v) & rol8(v)) ^ rol2(v), computed in WORD bits with no carries.
  - Encrypt: x' = y ^ f(x) ^ k; y' = x.
  - Decrypt: y' = x ^ f(y) ^ k; x' = y.
- `idx` moves by ±1 per applied round.
- `ks_ready[idx]`=0 → stall: hold x, y and `idx`.
- After the round at idx 31 (encrypt) or idx 0 (decrypt), go to DONE.

DONE:
- `out_valid`=1 and `out_data`={x,y}, held stable until `out_ready`.
- Then go to IDLE.

Other rules:
- `ks_hold`=0 outside LOAD_KEY and reset, so the schedule finishes and stays valid for cached reuse.
- `in_ready` and `out_valid` are never high in the same cycle. The block holds one operation at a time.
- Reset values: `in_ready`=0 in the reset cycle and 1 afterwards; `out_valid`=0; `out_data`=0; `ks_hold`=1; `ks_key`=0; `busy`=0; `round_idx`=0; `key_loaded`=0.
- Reset mid-operation drops the block with no output, forces LOAD_KEY on the next request, and holds the expansion.

## Timing
Accept happens at cycle 0.

Encrypt with a new key:
- LOAD_KEY at cycle 1.
- Rounds at cycles 2..33, with no stalls: key i becomes ready at RUN cycle i-3.
- `out_valid` from cycle 34.

Encrypt with the cached key:
- Rounds at cycles 1..32.
- `out_valid` from cycle 33.

Decrypt with a new key:
- Stalls until `ks_ready[31]`, which rises at RUN cycle 28.
- `out_valid` from cycle 62.

Decrypt with the cached key: same latency as cached encrypt.

Registers and back-pressure:
- All outputs are registered.
- With `out_ready` held high, the result is consumed in its first valid cycle, and `in_ready` rises on the next cycle.

## Configuration
Macro `SIMON_DECRYPT_EN`:
- Defined: the `in_decrypt` mode is latched at accept, and the descending-index decrypt path is compiled in.
- Undefined: `in_decrypt` is ignored, the mode bit is tied to encrypt, and the decrypt round logic is absent.

## Structure
Package `simon_pkg` holds:
- `SIMON_ROUNDS`=32 and `SIMON_WORD`=16.
- State enum `simon_ctrl_state_t` (IDLE, LOAD_KEY, RUN, DONE).
- Function `simon_f`.

Sub-module `simon_round`:
- Combinational, one round.
- Inputs: x, y, k, decrypt.
- Outputs: x', y'.

## Test plan
- Known-answer encrypt: `in_key`=64'h1918_1110_0908_0100, `in_new_key`=1, `in_data`=32'h6565_6877 → `out_data`=32'hc69b_e9bb; `out_valid` first rises at cycle 34.
- Cached key: repeat the same block with `in_new_key`=0 → same ciphertext; `out_valid` at cycle 33; `ks_hold` never asserted.
- Back-pressure: hold `out_ready`=0 for 10 cycles → `out_data` stable; `in_ready`=0 throughout.
- Stall: force `ks_ready[7]`=0 for 5 cycles → `round_idx` holds at 7; result is still c69be9bb, 5 cycles later than without the stall.
- Reset at round 12 → `out_valid` never pulses for that block; `ks_hold`=1 during reset; the next request passes through LOAD_KEY.
- With `SIMON_DECRYPT_EN`: decrypt 32'hc69b_e9bb under the same key → 32'h6565_6877.

Source files
------------

// File: rtl/simon_round_ctrl_pkg.sv
// Shared Simon 32/64 constants, sequencer state encoding and the round function f.
package simon_pkg;

  localparam int SIMON_ROUNDS = 32;
  localparam int SIMON_WORD   = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KEY,
    RUN,
    DONE
  } simon_ctrl_state_t;

  // f(v) = (rol1 & rol8) ^ rol2, pure bit rotation with no carries
  function automatic logic [SIMON_WORD-1:0] simon_f(input logic [SIMON_WORD-1:0] v);
    logic [SIMON_WORD-1:0] r1, r2, r8;
    r1 = {v[SIMON_WORD-2:0], v[SIMON_WORD-1]};
    r2 = {v[SIMON_WORD-3:0], v[SIMON_WORD-1 -: 2]};
    r8 = {v[SIMON_WORD-9:0], v[SIMON_WORD-1 -: 8]};
    return (r1 & r8) ^ r2;
  endfunction

endpackage

// File: rtl/simon_round_ctrl_if.sv
// Block request / result handshake between the bus wrapper (master) and the round sequencer (slave).
interface simon_round_ctrl_if
  import simon_pkg::*;
#(
  parameter int WORD = SIMON_WORD
);
  logic                in_valid;
  logic                in_ready;
  logic [2*WORD-1:0]   in_data;
  logic [4*WORD-1:0]   in_key;
  logic                in_new_key;
  logic                in_decrypt;
  logic                out_valid;
  logic                out_ready;
  logic [2*WORD-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_key, in_new_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_new_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/simon_round_ctrl_round.sv
// One combinational Simon Feistel round; SIMON_DECRYPT_EN compiles in the inverse round.
module simon_round
  import simon_pkg::*;
#(
  parameter int WORD = SIMON_WORD
) (
  input  logic [WORD-1:0] x_i,
  input  logic [WORD-1:0] y_i,
  input  logic [WORD-1:0] k_i,
  input  logic            decrypt_i,
  output logic [WORD-1:0] x_o,
  output logic [WORD-1:0] y_o
);

`ifdef SIMON_DECRYPT_EN
  always_comb begin
    if (decrypt_i) begin
      x_o = y_i;
      y_o = x_i ^ simon_f(y_i) ^ k_i;
    end else begin
      x_o = y_i ^ simon_f(x_i) ^ k_i;
      y_o = x_i;
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt_i;
  assign x_o = y_i ^ simon_f(x_i) ^ k_i;
  assign y_o = x_i;
`endif

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon 32/64 round sequencer: loads or reuses the key schedule, then applies ROUNDS rounds.
// Build macro SIMON_DECRYPT_EN latches in_decrypt and enables the descending-index decrypt path.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int WORD   = SIMON_WORD
) (
  input  logic                        clk,
  input  logic                        rst,
  simon_round_ctrl_if.slave           bus,
  output logic                        ks_hold,
  output logic [3:0][WORD-1:0]        ks_key,
  input  logic [ROUNDS-1:0]           ks_ready,
  input  logic [ROUNDS-1:0][WORD-1:0] ks_rk,
  output logic                        busy,
  output logic [$clog2(ROUNDS)-1:0]   round_idx
);

  localparam int            IW       = $clog2(ROUNDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

  simon_ctrl_state_t   state_q;
  logic [WORD-1:0]     x_q, y_q;
  logic                dec_q;
  logic [IW-1:0]       idx_q;
  logic                key_loaded_q;
  logic                in_ready_q, out_valid_q, ks_hold_q, busy_q;
  logic [3:0][WORD-1:0] ks_key_q;

  logic mode_d;
`ifdef SIMON_DECRYPT_EN
  assign mode_d = bus.in_decrypt;
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.in_decrypt;
  assign mode_d = 1'b0;
`endif

  logic [WORD-1:0] x_d, y_d;
  logic [IW-1:0]   idx_d;
  logic            last_round;

  simon_round #(.WORD(WORD)) u_round (
    .x_i      (x_q),
    .y_i      (y_q),
    .k_i      (ks_rk[idx_q]),
    .decrypt_i(dec_q),
    .x_o      (x_d),
    .y_o      (y_d)
  );

  assign idx_d      = dec_q ? idx_q - IW'(1) : idx_q + IW'(1);
  assign last_round = dec_q ? (idx_q == '0) : (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      dec_q        <= 1'b0;
      idx_q        <= '0;
      key_loaded_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ks_hold_q    <= 1'b1;
      ks_key_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          ks_hold_q  <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            x_q        <= bus.in_data[2*WORD-1:WORD];
            y_q        <= bus.in_data[WORD-1:0];
            dec_q      <= mode_d;
            idx_q      <= mode_d ? LAST_IDX : '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // an explicit reload request is meaningless until a key exists
            if (!key_loaded_q || bus.in_new_key) begin
              ks_key_q  <= bus.in_key;
              ks_hold_q <= 1'b1;
              state_q   <= LOAD_KEY;
            end else begin
              state_q <= RUN;
            end
          end
        end
        LOAD_KEY: begin
          ks_hold_q    <= 1'b0;
          key_loaded_q <= 1'b1;
          state_q      <= RUN;
        end
        RUN: begin
          if (ks_ready[idx_q]) begin
            x_q <= x_d;
            y_q <= y_d;
            if (last_round) begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = {x_q, y_q};
  assign ks_hold       = ks_hold_q;
  assign ks_key        = ks_key_q;
  assign busy          = busy_q;
  assign round_idx     = idx_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Randomized and directed bench for simon_round_ctrl with a key_expansion model and a Simon reference cipher.
`timescale 1ns/1ps
module tb_simon_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_round_ctrl_if #(.WORD(16)) bus ();
  logic              ks_hold;
  logic [3:0][15:0]  ks_key;
  logic [31:0]       ks_ready;
  logic [31:0][15:0] ks_rk;
  logic              busy;
  logic [4:0]        round_idx;

  simon_round_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ks_hold  (ks_hold),
    .ks_key   (ks_key),
    .ks_ready (ks_ready),
    .ks_rk    (ks_rk),
    .busy     (busy),
    .round_idx(round_idx)
  );

  localparam logic [63:0] KA_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KA_PT  = 32'h6565_6877;
  localparam logic [31:0] KA_CT  = 32'hc69b_e9bb;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rst_prev = 1'b1;
  int          load_cyc = -100;
  bit          mon_en = 1'b0;
  bit          key_loaded_m = 1'b0;
  logic [63:0] cur_key = '0;
  logic [31:0] last_out = '0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Simon 32/64 key schedule step producing key i+4 from keys i, i+1, i+3
  function automatic logic [15:0] next_key(input logic [15:0] k0, input logic [15:0] k1,
                                           input logic [15:0] k3, input int i);
    logic [61:0] z;
    logic [15:0] t;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    t = ror(k3, 3) ^ k1;
    t = t ^ ror(t, 1);
    return ~k0 ^ t ^ 16'(z[61-i]) ^ 16'd3;
  endfunction

  function automatic logic [31:0] ref_cipher(input logic [63:0] key, input logic [31:0] blk, input bit dec);
    logic [15:0] rk[32];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) rk[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) rk[i] = next_key(rk[i-4], rk[i-3], rk[i-1], i - 4);
    x = blk[31:16];
    y = blk[15:0];
    if (!dec) begin
      for (int r = 0; r < 32; r++) begin
        t = x; x = y ^ ff(x) ^ rk[r]; y = t;
      end
    end else begin
      for (int r = 31; r >= 0; r--) begin
        t = y; y = x ^ ff(y) ^ rk[r]; x = t;
      end
    end
    return {x, y};
  endfunction

  function automatic bit dec_eff(input bit d);
`ifdef SIMON_DECRYPT_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  // key_expansion model: loads while held, then releases one new key per cycle
  logic [15:0] exp_k[32];
  int          exp_n = 0;
  logic [31:0] stall_mask = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
    if (ks_hold === 1'b1) begin
      for (int i = 0; i < 4; i++) exp_k[i] <= ks_key[i];
      exp_n <= 4;
    end else if (exp_n >= 4 && exp_n < 32) begin
      exp_k[exp_n] <= next_key(exp_k[exp_n-4], exp_k[exp_n-3], exp_k[exp_n-1], exp_n - 4);
      exp_n <= exp_n + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      ks_ready[i] = (i < exp_n) && !stall_mask[i];
      ks_rk[i]    = exp_k[i];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready_and_out_valid", 64'(bus.in_ready && bus.out_valid), 64'd0);
      chk("ks_hold", 64'(ks_hold), 64'(rst_prev || (cyc == load_cyc)));
      if (rst_prev) chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      else          chk("busy_vs_in_ready", 64'(busy), 64'(!bus.in_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
        else begin
          chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [63:0] key, input logic [31:0] blk, input bit nk, input bit dec,
                        output int c0, output bit loading);
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin step(); t++; end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    loading = !key_loaded_m || nk;
    if (loading) begin
      cur_key      = key;
      load_cyc     = cyc + 1;
      key_loaded_m = 1'b1;
    end
    exp_q.push_back(ref_cipher(cur_key, blk, dec_eff(dec)));
    bus.in_valid   = 1'b1;
    bus.in_data    = blk;
    bus.in_key     = key;
    bus.in_new_key = nk;
    bus.in_decrypt = dec;
    c0 = cyc;
    step();
    bus.in_valid   = 1'b0;
    bus.in_data    = $urandom;
    bus.in_key     = {$urandom, $urandom};
    bus.in_new_key = 1'($urandom);
    bus.in_decrypt = 1'($urandom);
  endtask

  // stall_len > 0 masks ks_ready[7] from cycle 8 (cached encrypt only)
  task automatic run_op(input logic [63:0] key, input logic [31:0] blk, input bit nk, input bit dec,
                        input int rdy_delay, input int stall_len);
    int c0, t, lat;
    bit loading;
    logic [31:0] exp;
    accept(key, blk, nk, dec, c0, loading);
    exp = exp_q[exp_q.size()-1];
    lat = (loading ? (dec_eff(dec) ? 62 : 34) : 33) + stall_len;
    t = 0;
    while (!bus.out_valid && t < 200) begin
      if (stall_len > 0) begin
        if (cyc - c0 == 8) stall_mask[7] = 1'b1;
        if (cyc - c0 == 8 + stall_len) stall_mask = '0;
        if (cyc - c0 >= 8 && cyc - c0 <= 8 + stall_len) chk("stall_round_idx", 64'(round_idx), 64'd7);
      end
      step();
      t++;
    end
    stall_mask = '0;
    chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
    chk("latency", 64'(cyc - c0), 64'(lat));
    last_out = bus.out_data;
    for (int i = 0; i < rdy_delay; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_data", 64'(bus.out_data), 64'(exp));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("in_ready_rise", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic reset_mid_op();
    int c0, t;
    bit loading;
    accept(KA_KEY, KA_PT, 1'b1, 1'b0, c0, loading);
    t = 0;
    while (cyc - c0 < 14 && t < 100) begin step(); t++; end
    chk("pre_reset_round_idx", 64'(round_idx), 64'd12);
    rst = 1'b1;
    exp_q.delete();
    key_loaded_m = 1'b0;
    step();
    chk("mid_reset_ks_hold", 64'(ks_hold), 64'd1);
    chk("mid_reset_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_key     = '0;
    bus.in_new_key = 1'b0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_ks_hold", 64'(ks_hold), 64'd1);
    chk("rst_ks_key", 64'(ks_key), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_round_idx", 64'(round_idx), 64'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    chk("model_known_answer", 64'(ref_cipher(KA_KEY, KA_PT, 1'b0)), 64'(KA_CT));
    chk("model_inverse", 64'(ref_cipher(KA_KEY, KA_CT, 1'b1)), 64'(KA_PT));

    run_op(KA_KEY, KA_PT, 1'b1, 1'b0, 0, 0);
    chk("ka_new_key", 64'(last_out), 64'(KA_CT));
    run_op(64'h0, KA_PT, 1'b0, 1'b0, 0, 0);
    chk("ka_cached", 64'(last_out), 64'(KA_CT));
    run_op(64'h0, KA_PT, 1'b0, 1'b0, 10, 0);
    chk("ka_backpressure", 64'(last_out), 64'(KA_CT));
    run_op(64'h0, KA_PT, 1'b0, 1'b0, 0, 5);
    chk("ka_stall", 64'(last_out), 64'(KA_CT));

    reset_mid_op();
    run_op(KA_KEY, KA_PT, 1'b0, 1'b0, 1, 0);
    chk("ka_after_reset", 64'(last_out), 64'(KA_CT));

`ifdef SIMON_DECRYPT_EN
    run_op(KA_KEY, KA_CT, 1'b1, 1'b1, 0, 0);
    chk("ka_decrypt_new", 64'(last_out), 64'(KA_PT));
    run_op(KA_KEY, KA_CT, 1'b0, 1'b1, 2, 0);
    chk("ka_decrypt_cached", 64'(last_out), 64'(KA_PT));
`endif

    for (int n = 0; n < 16; n++) begin
      run_op({$urandom, $urandom}, $urandom, ($urandom_range(0, 2) == 0), 1'($urandom),
             $urandom_range(0, 3), 0);
    end
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
